// File: rtl/mem_access_stage.sv
// Memory-access stage: pass-through of ALU results and LW/SW request/ack handshake with data memory.
// Optional alignment fault detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write_in,
    input  logic [4:0]  wr_reg_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        bus_error,
    output logic        misalign
);

    typedef enum logic [1:0] {StIdle, StAccess, StErr} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_load_q, is_load_d;
    logic        pend_we_q, pend_we_d;
    logic [4:0]  pend_reg_q, pend_reg_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        bus_error_q, bus_error_d;
    logic        misalign_q, misalign_d;
    logic        stall_c;
    logic        memop;
    logic        misaligned;

    assign memop = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = memop & (alu_out[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_load_d   = is_load_q;
        pend_we_d   = pend_we_q;
        pend_reg_d  = pend_reg_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        bus_error_d = bus_error_q;
        misalign_d  = 1'b0;
        stall_c     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    if (memop && !misaligned) begin
                        stall_c    = 1'b1;
                        state_d    = StAccess;
                        cnt_d      = 8'd0;
                        req_d      = 1'b1;
                        // Both read and write set resolves to a read.
                        we_d       = mem_write & ~mem_read;
                        addr_d     = {alu_out[31:2], 2'b00};
                        wdata_d    = store_data;
                        is_load_d  = mem_read;
                        pend_we_d  = reg_write_in;
                        pend_reg_d = wr_reg_in;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_out;
                        wb_reg_d   = wr_reg_in;
                        wb_we_d    = reg_write_in & ~misaligned;
                        misalign_d = misaligned;
                    end
                end
            end
            StAccess: begin
                stall_c = ~dmem_ack;
                if (dmem_ack) begin
                    state_d    = StIdle;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = pend_reg_q;
                    wb_data_d  = is_load_q ? dmem_rdata : addr_q;
                    wb_we_d    = is_load_q & pend_we_q;
                end else if (cnt_q == TimeoutLast) begin
                    // This was the last permitted ACCESS cycle.
                    state_d     = StErr;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StErr: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            is_load_q   <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_reg_q  <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_reg_q    <= 5'd0;
            wb_data_q   <= 32'd0;
            bus_error_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_load_q   <= is_load_d;
            pend_we_q   <= pend_we_d;
            pend_reg_q  <= pend_reg_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            bus_error_q <= bus_error_d;
            misalign_q  <= misalign_d;
        end
    end

    assign stall      = stall_c & ~rst;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_reg     = wb_reg_q;
    assign wb_data    = wb_data_q;
    assign bus_error  = bus_error_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: transaction-level model checked every cycle,
// plus literal expectations from the test plan.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] store_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write_in = 1'b0;
    logic [4:0]  wr_reg_in = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall, dmem_req, dmem_we, wb_valid, wb_we, bus_error, misalign;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [4:0]  wb_reg;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_out(alu_out),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write_in(reg_write_in), .wr_reg_in(wr_reg_in), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .bus_error(bus_error), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding memory transaction with an age in ACCESS cycles.
    bit          m_busy = 1'b0, m_err = 1'b0;
    int unsigned m_age = 0;
    bit          m_load = 1'b0, m_rw = 1'b0;
    logic [4:0]  m_preg = '0;
    logic        e_req = 1'b0, e_we = 1'b0, e_wbv = 1'b0, e_wbwe = 1'b0, e_berr = 1'b0, e_mis = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_wbdata = '0;
    logic [4:0]  e_wbreg = '0;

    function automatic bit is_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
        return (mem_read || mem_write) && (alu_out[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        e_wbv  <= 1'b0;
        e_wbwe <= 1'b0;
        e_mis  <= 1'b0;
        if (rst) begin
            m_busy <= 1'b0; m_err <= 1'b0; m_age <= 0;
            e_req <= 1'b0; e_we <= 1'b0; e_addr <= '0; e_wdata <= '0;
            e_wbdata <= '0; e_wbreg <= '0; e_berr <= 1'b0;
        end else if (m_err) begin
            // stuck until reset
        end else if (m_busy) begin
            if (dmem_ack) begin
                m_busy   <= 1'b0;
                e_req    <= 1'b0;
                e_wbv    <= 1'b1;
                e_wbreg  <= m_preg;
                e_wbdata <= m_load ? dmem_rdata : e_addr;
                e_wbwe   <= m_load && m_rw;
            end else if (m_age + 1 >= TIMEOUT) begin
                m_err  <= 1'b1;
                e_req  <= 1'b0;
                e_berr <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (valid_in) begin
            if ((mem_read || mem_write) && !is_misaligned()) begin
                m_busy  <= 1'b1;
                m_age   <= 0;
                m_load  <= mem_read;
                m_rw    <= reg_write_in;
                m_preg  <= wr_reg_in;
                e_req   <= 1'b1;
                e_we    <= mem_write && !mem_read;
                e_addr  <= alu_out & 32'hFFFF_FFFC;
                e_wdata <= store_data;
            end else begin
                e_wbv    <= 1'b1;
                e_wbdata <= alu_out;
                e_wbreg  <= wr_reg_in;
                e_wbwe   <= reg_write_in && !is_misaligned();
                e_mis    <= is_misaligned();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_stall;
            if (rst) e_stall = 1'b0;
            else if (m_err) e_stall = 1'b1;
            else if (m_busy) e_stall = !dmem_ack;
            else e_stall = valid_in && (mem_read || mem_write) && !is_misaligned();
            check("m_stall", 32'(stall), 32'(e_stall));
            check("m_dmem_req", 32'(dmem_req), 32'(e_req));
            check("m_wb_valid", 32'(wb_valid), 32'(e_wbv));
            check("m_wb_we", 32'(wb_we), 32'(e_wbwe));
            check("m_wb_reg", 32'(wb_reg), 32'(e_wbreg));
            check("m_wb_data", wb_data, e_wbdata);
            check("m_bus_error", 32'(bus_error), 32'(e_berr));
            check("m_misalign", 32'(misalign), 32'(e_mis));
            if (e_req) begin
                check("m_dmem_we", 32'(dmem_we), 32'(e_we));
                check("m_dmem_addr", dmem_addr, e_addr);
                check("m_dmem_wdata", dmem_wdata, e_wdata);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                         input logic rd, input logic wr, input logic rw, input logic [4:0] r);
        valid_in = v; alu_out = a; store_data = sd;
        mem_read = rd; mem_write = wr; reg_write_in = rw; wr_reg_in = r;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        cyc();
        rst = 1'b0;

        // ADD pass-through
        drive(1'b1, 32'h25, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        @(negedge clk);
        check("add_stall", 32'(stall), 32'd0);
        cyc();
        idle();
        @(negedge clk);
        check("add_wb_valid", 32'(wb_valid), 32'd1);
        check("add_wb_data", wb_data, 32'h25);
        check("add_wb_reg", 32'(wb_reg), 32'd5);
        check("add_wb_we", 32'(wb_we), 32'd1);

        // LW 0x104, ack in third ACCESS cycle
        drive(1'b1, 32'h104, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7);
        @(negedge clk);
        check("lw_stall_accept", 32'(stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            check("lw_addr", dmem_addr, 32'h104);
            check("lw_stall", 32'(stall), 32'd1);
        end
        cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("lw_stall_ack", 32'(stall), 32'd0);
        cyc();
        dmem_ack = 1'b0; idle();
        @(negedge clk);
        check("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        check("lw_wb_we", 32'(wb_we), 32'd1);
        check("lw_req_drop", 32'(dmem_req), 32'd0);

        // SW 0x10 with immediate ack, then back-to-back ADD
        drive(1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd0);
        cyc();
        dmem_ack = 1'b1;
        @(negedge clk);
        check("sw_we", 32'(dmem_we), 32'd1);
        check("sw_wdata", dmem_wdata, 32'h1234_5678);
        cyc();
        dmem_ack = 1'b0;
        drive(1'b1, 32'h99, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
        @(negedge clk);
        check("sw_wb_valid", 32'(wb_valid), 32'd1);
        check("sw_wb_we", 32'(wb_we), 32'd0);
        check("sw_wb_data", wb_data, 32'h10);
        cyc();
        idle();
        @(negedge clk);
        check("b2b_wb_data", wb_data, 32'h99);
        check("b2b_wb_reg", 32'(wb_reg), 32'd3);

        // Ack in the TIMEOUT-th ACCESS cycle completes normally
        drive(1'b1, 32'h200, 32'd0, 1'b1, 1'b0, 1'b1, 5'd9);
        for (int i = 0; i < int'(TIMEOUT); i++) cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        cyc();
        dmem_ack = 1'b0; idle();
        @(negedge clk);
        check("bnd_wb_data", wb_data, 32'hCAFE_F00D);
        check("bnd_bus_error", 32'(bus_error), 32'd0);

        // Reset in second ACCESS cycle with ack
        drive(1'b1, 32'h300, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4);
        cyc();
        cyc();
        rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        cyc();
        rst = 1'b0; dmem_ack = 1'b0; idle();
        @(negedge clk);
        check("rsta_wb_valid", 32'(wb_valid), 32'd0);
        check("rsta_req", 32'(dmem_req), 32'd0);
        check("rsta_wb_data", wb_data, 32'd0);

        // Misaligned LW 0x102
        drive(1'b1, 32'h102, 32'd0, 1'b1, 1'b0, 1'b1, 5'd6);
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        check("mis_stall", 32'(stall), 32'd0);
        cyc();
        idle();
        @(negedge clk);
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_wb_we", 32'(wb_we), 32'd0);
        check("mis_req", 32'(dmem_req), 32'd0);
        cyc();
        @(negedge clk);
        check("mis_drop", 32'(misalign), 32'd0);
`else
        cyc();
        dmem_ack = 1'b1; dmem_rdata = 32'h55;
        @(negedge clk);
        check("mis_addr", dmem_addr, 32'h100);
        cyc();
        dmem_ack = 1'b0; idle();
        @(negedge clk);
        check("mis_none", 32'(misalign), 32'd0);
        check("mis_wb_data", wb_data, 32'h55);
`endif

        // Timeout into ERR
        drive(1'b1, 32'h400, 32'hAAAA_5555, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i <= int'(TIMEOUT); i++) cyc();
        @(negedge clk);
        check("to_bus_error", 32'(bus_error), 32'd1);
        check("to_req", 32'(dmem_req), 32'd0);
        check("to_stall", 32'(stall), 32'd1);
        dmem_ack = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        check("to_stuck", 32'(stall), 32'd1);
        check("to_no_wb", 32'(wb_valid), 32'd0);
        dmem_ack = 1'b0; idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_berr", 32'(bus_error), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_wb_data", wb_data, 32'd0);
        check("post_rst_addr", dmem_addr, 32'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage directly downstream of the execute-stage ALU. Consumes the ALU result as a load/store address or a pass-through result. Runs a request/acknowledge transaction with data memory for LW/SW, stalling upstream until the memory responds. Presents a registered write-back bundle to the register-file stage.

## Interface
- `TIMEOUT`, 16: consecutive ACCESS cycles without `dmem_ack` before a bus error; legal range 2–255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_in` in 1: execute-stage bundle valid this cycle.
- `alu_out` in 32: ALU result; a byte address when `mem_read` or `mem_write` is set.
- `store_data` in 32: rt value for SW.
- `mem_read` in 1: LW.
- `mem_write` in 1: SW.
- `reg_write_in` in 1: instruction writes the register file.
- `wr_reg_in` in 5: destination register number.
- `stall` out 1: combinational; upstream holds all inputs while high.
- `dmem_req` out 1: memory request, registered.
- `dmem_we` out 1: request is a write.
- `dmem_addr` out 32: word address.
- `dmem_wdata` out 32: store data.
- `dmem_ack` in 1: memory completes the request this cycle.
- `dmem_rdata` in 32: read data; valid when `dmem_ack` is high.
- `wb_valid` out 1: write-back bundle valid; one-cycle pulse per instruction.
- `wb_we` out 1: register-file write enable.
- `wb_reg` out 5: destination register.
- `wb_data` out 32: write-back data.
- `bus_error` out 1: sticky timeout flag.
- `misalign` out 1: one-cycle alignment-fault pulse.

## Operation
- FSM states: IDLE, ACCESS, ERR. Reset enters IDLE.
- Memory op (memop) = `mem_read | mem_write`. If both are high, the instruction is treated as a read and `dmem_we` = 0.
- **IDLE, `valid_in` with no memop:**
  - Next edge: `wb_valid`=1, `wb_data`=`alu_out`, `wb_reg`=`wr_reg_in`, `wb_we`=`reg_write_in`.
  - `stall` stays 0.
- **IDLE, `valid_in` with memop:**
  - `stall`=1 in the same cycle.
  - Latch address, data, read/write, `wr_reg_in` and `reg_write_in`.
  - Next edge: enter ACCESS with `dmem_req`=1, `dmem_addr`={`alu_out[31:2]`,2'b00}, `dmem_we`=`mem_write & ~mem_read`, `dmem_wdata`=`store_data`.
- **ACCESS:**
  - `dmem_req`, `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable.
  - `valid_in` is ignored.
  - `stall` = `~dmem_ack`.
  - On `dmem_ack`:
    - Next edge returns to IDLE, drops `dmem_req` and pulses `wb_valid`.
    - Load: `wb_data`=`dmem_rdata`, `wb_we`=latched `reg_write_in`.
    - Store: `wb_data`=latched address, `wb_we`=0.
- **Timeout counter:**
  - Counts ACCESS cycles; cleared on entry to ACCESS.
  - If the count reaches `TIMEOUT` without an ack, the next edge enters ERR.
- **ERR:**
  - `dmem_req`=0, `bus_error`=1, `stall`=1.
  - No write-back; exit only via `rst`.
- `dmem_ack` outside ACCESS is ignored.
- `wb_valid`, `wb_we` and `misalign` are single-cycle pulses and return to 0 otherwise. `wb_data` and `wb_reg` hold their last value.

## Timing
- Reset values: `stall`=0 (while `rst`=1), `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `wb_valid`=0, `wb_we`=0, `wb_reg`=0, `wb_data`=0, `bus_error`=0, `misalign`=0. Counter=0, state=IDLE.
- Non-memory latency: 1 cycle from acceptance to `wb_valid`.
- Memory latency: 1 accept cycle + N ACCESS cycles (N ≥ 1, ack in the Nth) → `wb_valid` on the edge after the ack. Minimum is 2 cycles, with ack in the first ACCESS cycle.
- Upstream advance: stall drops combinationally in the ack cycle, so upstream advances on that same edge. A new instruction is presented in the cycle `wb_valid` is high and is accepted back-to-back.
- Reset during ACCESS: `dmem_req` drops on the reset edge. An ack in that cycle is discarded and no `wb_valid` is produced.
- Timeout boundary: an ack arriving in the TIMEOUT-th ACCESS cycle completes normally; ERR is entered only if that cycle also lacks an ack.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - A memop in IDLE with `alu_out[1:0]` ≠ 0 issues no request and does not stall.
  - Next edge: `misalign`=1, `wb_valid`=1, `wb_we`=0, `wb_data`=`alu_out`.
- Undefined:
  - Address bits [1:0] are dropped silently.
  - `misalign` is tied to 0; the port is always present.

## Test plan
- Reset, then `valid_in` with `alu_out`=0x0000_0025, `reg_write_in`=1, `wr_reg_in`=5, no memop → next cycle `wb_valid`=1, `wb_data`=0x25, `wb_reg`=5, `wb_we`=1; `stall` never asserted.
- LW at `alu_out`=0x0000_0104, ack on the 3rd ACCESS cycle with `dmem_rdata`=0xDEAD_BEEF → `dmem_addr`=0x104 held for 3 cycles, `stall` high for 3 cycles, then `wb_data`=0xDEAD_BEEF with `wb_we`=1.
- SW at 0x0000_0010 with `store_data`=0x1234_5678 and immediate ack → `dmem_we`=1, `dmem_wdata`=0x1234_5678, then `wb_valid`=1 with `wb_we`=0. A following ADD is accepted on the next cycle.
- `TIMEOUT`=4 with no ack → `bus_error`=1 after 4 ACCESS cycles, `dmem_req`=0, `stall` stuck at 1 until `rst`, after which all outputs are 0.
- `rst` pulsed in the 2nd ACCESS cycle while `dmem_ack`=1 → no `wb_valid`, `dmem_req`=0, state IDLE.
- `MEM_ALIGN_CHECK_EN` defined, LW at 0x0000_0102 → no `dmem_req`, `misalign`=1 and `wb_valid`=1 for one cycle with `wb_we`=0.
